lru_fill_ctrl: RTL and testbench
================================

# lru_fill_ctrl

Recency-ordered allocation controller for a small fully-associative buffer of DEPTH entries, such as cache fill/MSHR slots. It keeps a per-entry valid bit, a tag and an LRU→MRU ordering. It serves three kinds of traffic: one allocator, NUM_REQS lookup requesters behind a round-robin arbiter, and one release port, plus a multi-cycle flush sequence. It sits between the cache bank's request pipeline and the entry storage and decides which entry index each fill uses or evicts.

## Interface
- DEPTH, 4: number of entries; power of 2, 2..16; ADDRW = `CLOG2(DEPTH)`.
- TAGW, 8: tag width.
- NUM_REQS, 2: lookup requesters, 1..4; REQW = `CLOG2(NUM_REQS)` (min 1).
- clk  in  1  clock, all state on posedge.
- reset  in  1  asynchronous, active-low: 0 resets all state immediately; released synchronously by the environment.
- alloc_valid  in  1  allocation request.
- alloc_tag  in  TAGW  tag to install.
- alloc_ready  out  1  allocation accepted this cycle when alloc_valid is also 1.
- alloc_idx  out  ADDRW  entry chosen; combinational, meaningful while alloc_valid.
- alloc_evict  out  1  chosen entry currently valid (victim).
- alloc_evict_tag  out  TAGW  tag of the victim.
- lkp_valid  in  NUM_REQS  per-requester lookup request.
- lkp_tag  in  NUM_REQS*TAGW  per-requester tag, requester i at bits [i*TAGW +: TAGW].
- lkp_ready  out  NUM_REQS  one-hot grant, at most one bit set.
- lkp_rsp_valid  out  1  registered lookup response.
- lkp_rsp_hit  out  1  tag matched a valid entry.
- lkp_rsp_idx  out  ADDRW  matching entry (0 on miss).
- lkp_rsp_req  out  REQW  granted requester id.
- release_valid  in  1  invalidate an entry.
- release_idx  in  ADDRW  entry to invalidate.
- flush  in  1  start flush (pulse).
- flush_busy  out  1  flush sequence in progress.
- size  out  `CLOG2(DEPTH+1)`  count of valid entries.

## Operation
- State:
  - valid[DEPTH] and tag[DEPTH].
  - order[DEPTH], a permutation of entry indices; order[0] is LRU and order[DEPTH-1] is MRU.
  - Round-robin pointer rr (REQW bits).
  - FSM IDLE/FLUSH with flush counter fcnt (ADDRW bits).
- Reset:
  - valid=0, order[i]=i, rr=0, FSM=IDLE, fcnt=0, all registered outputs 0.
  - The tag array is not reset.
- One list update per cycle, priority: flush start > release > alloc > lookup.
- Release (IDLE, release_valid): clear valid[release_idx] and move that index to order[0]. Other entries keep their relative order. Releasing an invalid entry only reorders.
- Alloc:
  - alloc_ready = IDLE & ~release_valid & ~flush.
  - Victim is the lowest-numbered invalid entry if any exists; otherwise order[0].
  - On fire: tag[victim]=alloc_tag, valid=1, victim moves to MRU, others shift down.
  - alloc_evict = valid[victim].
  - The caller never allocates a tag already present; the simulation assertion fires on a duplicate.
- Lookup arbitration:
  - Eligible only when IDLE & ~release_valid & ~(alloc_valid & alloc_ready) & ~flush.
  - The grant goes to the first requester with lkp_valid set, scanning from rr upward with wrap.
  - On grant, rr = granted+1 mod NUM_REQS. rr does not move without a grant.
- Lookup result:
  - The granted tag is compared against all valid entries.
  - On a hit, the entry moves to MRU.
  - Response registered next cycle: lkp_rsp_valid=1 for exactly one cycle per grant, with hit/idx/req.
- Flush:
  - flush in IDLE enters FLUSH: valid[fcnt] cleared each cycle, fcnt 0..DEPTH-1.
  - After DEPTH cycles: order reset to identity, rr=0, return to IDLE.
  - flush_busy=1 for the whole FLUSH state.
  - flush asserted during FLUSH is ignored.
  - release, alloc and lookup are all stalled during FLUSH (ready=0).
- size = popcount(valid), registered, updated with the state changes.

## Timing
- Alloc: zero-latency decision. alloc_idx/evict are combinational from state; the state update is visible on the next cycle.
- Lookup: grant in cycle N, response in cycle N+1. The MRU promotion is visible in cycle N+1 state.
- Back-to-back grants are allowed every cycle; a response in N+1 and a new grant in N+1 are independent.
- Release in cycle N: entry invalid from N+1; alloc in the same cycle N is blocked.
- Flush accepted in N: flush_busy=1 in N+1..N+DEPTH, IDLE in N+DEPTH+1, and alloc_ready may be 1 in that cycle.
- Reset asserted mid-flush or mid-lookup: FLUSH aborted, pending lkp_rsp_valid dropped to 0, state as at reset.

## Test plan
- Fill (DEPTH=4): four allocs with tags 0x10..0x13 -> alloc_idx 0,1,2,3, alloc_evict=0, size=4, order=[0,1,2,3].
- Evict: then lookup tag 0x10 by req0 -> rsp hit idx 0 one cycle later; then alloc 0x20 -> idx 1, evict=1, evict_tag=0x11.
- Arbitration: lkp_valid=2'b11 held for 4 cycles -> grants 01,10,01,10; lkp_rsp_req 0,1,0,1 each one cycle after its grant.
- Priority: release_valid idx 2 and alloc_valid in the same cycle -> alloc_ready=0; next cycle alloc -> idx 2, evict=0.
- Flush: assert flush with 4 valid entries -> flush_busy high 4 cycles, alloc_ready=0 throughout, then size=0 and first alloc -> idx 0.
- Reset: assert reset low during FLUSH cycle 2 -> flush_busy=0, size=0, lkp_rsp_valid=0 immediately.

Source files
------------

// File: rtl/lru_fill_ctrl.sv
// Recency-ordered allocation controller for a small fully-associative buffer.
// Tracks valid/tag per entry plus an LRU->MRU permutation; serves alloc, arbitrated lookup,
// release and a multi-cycle flush.
module lru_fill_ctrl #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned TAGW     = 8,
    parameter int unsigned NUM_REQS = 2,
    localparam int unsigned ADDRW   = $clog2(DEPTH),
    localparam int unsigned REQW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1,
    localparam int unsigned SIZEW   = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     alloc_valid,
    input  logic [TAGW-1:0]          alloc_tag,
    output logic                     alloc_ready,
    output logic [ADDRW-1:0]         alloc_idx,
    output logic                     alloc_evict,
    output logic [TAGW-1:0]          alloc_evict_tag,
    input  logic [NUM_REQS-1:0]      lkp_valid,
    input  logic [NUM_REQS*TAGW-1:0] lkp_tag,
    output logic [NUM_REQS-1:0]      lkp_ready,
    output logic                     lkp_rsp_valid,
    output logic                     lkp_rsp_hit,
    output logic [ADDRW-1:0]         lkp_rsp_idx,
    output logic [REQW-1:0]          lkp_rsp_req,
    input  logic                     release_valid,
    input  logic [ADDRW-1:0]         release_idx,
    input  logic                     flush,
    output logic                     flush_busy,
    output logic [SIZEW-1:0]         size
);

    typedef enum logic [0:0] {StIdle, StFlush} state_e;

    state_e            state_q;
    logic [ADDRW-1:0]  fcnt_q;
    logic [DEPTH-1:0]  valid_q, valid_d;
    logic [TAGW-1:0]   tag_q   [DEPTH];
    logic [ADDRW-1:0]  order_q [DEPTH];
    logic [ADDRW-1:0]  order_d [DEPTH];
    logic [REQW-1:0]   rr_q, rr_d;
    logic [SIZEW-1:0]  size_q, size_d;

    logic              idle, flush_done;
    logic              alloc_fire, release_fire, lkp_elig;
    logic [ADDRW-1:0]  victim;
    logic              victim_found;
    logic              alloc_dup;
    logic              gnt_any;
    logic [REQW-1:0]   gnt_id, cand;
    logic [TAGW-1:0]   gnt_tag;
    logic              hit;
    logic [ADDRW-1:0]  hit_idx;
    logic [ADDRW-1:0]  sel, pos;
    logic              to_mru, to_lru;

    assign idle         = (state_q == StIdle);
    assign flush_done   = (state_q == StFlush) && (fcnt_q == ADDRW'(DEPTH - 1));
    assign flush_busy   = (state_q == StFlush);
    assign alloc_ready  = idle & ~release_valid & ~flush;
    assign alloc_fire   = alloc_valid & alloc_ready;
    assign release_fire = idle & ~flush & release_valid;
    assign lkp_elig     = alloc_ready & ~alloc_valid;
    assign size         = size_q;

    // Prefer a free slot; only evict the LRU entry when the buffer is full.
    always_comb begin
        victim       = order_q[0];
        victim_found = 1'b0;
        alloc_dup    = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!valid_q[i] && !victim_found) begin
                victim       = ADDRW'(i);
                victim_found = 1'b1;
            end
            if (valid_q[i] && tag_q[i] == alloc_tag) alloc_dup = 1'b1;
        end
    end

    assign alloc_idx       = victim;
    assign alloc_evict     = valid_q[victim];
    assign alloc_evict_tag = tag_q[victim];

    always_comb begin
        gnt_any   = 1'b0;
        gnt_id    = '0;
        cand      = '0;
        lkp_ready = '0;
        if (lkp_elig) begin
            for (int k = 0; k < int'(NUM_REQS); k++) begin
                cand = REQW'((int'(rr_q) + k) % int'(NUM_REQS));
                if (!gnt_any && lkp_valid[cand]) begin
                    gnt_any = 1'b1;
                    gnt_id  = cand;
                end
            end
        end
        if (gnt_any) lkp_ready[gnt_id] = 1'b1;
    end

    assign gnt_tag = lkp_tag[int'(gnt_id) * int'(TAGW) +: TAGW];

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (!hit && valid_q[i] && tag_q[i] == gnt_tag) begin
                hit     = 1'b1;
                hit_idx = ADDRW'(i);
            end
        end
    end

    // One list update per cycle; flush start blocks everything via release_fire/alloc_ready.
    always_comb begin
        sel    = '0;
        to_mru = 1'b0;
        to_lru = 1'b0;
        if (release_fire) begin
            sel    = release_idx;
            to_lru = 1'b1;
        end else if (alloc_fire) begin
            sel    = victim;
            to_mru = 1'b1;
        end else if (gnt_any && hit) begin
            sel    = hit_idx;
            to_mru = 1'b1;
        end
        pos = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (order_q[i] == sel) pos = ADDRW'(i);
        end
        order_d = order_q;
        if (to_mru) begin
            for (int i = 0; i < int'(DEPTH) - 1; i++) begin
                if (i >= int'(pos)) order_d[i] = order_q[i+1];
            end
            order_d[DEPTH-1] = sel;
        end
        if (to_lru) begin
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (i <= int'(pos)) order_d[i] = order_q[i-1];
            end
            order_d[0] = sel;
        end
        if (flush_done) begin
            for (int i = 0; i < int'(DEPTH); i++) order_d[i] = ADDRW'(i);
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (state_q == StFlush)  valid_d[fcnt_q]      = 1'b0;
        else if (release_fire)   valid_d[release_idx] = 1'b0;
        else if (alloc_fire)     valid_d[victim]      = 1'b1;
        size_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) size_d = size_d + SIZEW'(valid_d[i]);
        rr_d = rr_q;
        if (gnt_any)    rr_d = REQW'((int'(gnt_id) + 1) % int'(NUM_REQS));
        if (flush_done) rr_d = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            fcnt_q        <= '0;
            valid_q       <= '0;
            rr_q          <= '0;
            size_q        <= '0;
            lkp_rsp_valid <= 1'b0;
            lkp_rsp_hit   <= 1'b0;
            lkp_rsp_idx   <= '0;
            lkp_rsp_req   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) order_q[i] <= ADDRW'(i);
        end else begin
            valid_q       <= valid_d;
            order_q       <= order_d;
            rr_q          <= rr_d;
            size_q        <= size_d;
            lkp_rsp_valid <= gnt_any;
            lkp_rsp_hit   <= gnt_any & hit;
            lkp_rsp_idx   <= (gnt_any && hit) ? hit_idx : '0;
            lkp_rsp_req   <= gnt_any ? gnt_id : '0;
            unique case (state_q)
                StIdle: begin
                    if (flush) begin
                        state_q <= StFlush;
                        fcnt_q  <= '0;
                    end
                end
                StFlush: begin
                    fcnt_q <= fcnt_q + 1'b1;
                    if (flush_done) begin
                        state_q <= StIdle;
                        fcnt_q  <= '0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Tag storage carries no reset; contents are qualified by valid_q.
    always_ff @(posedge clk) begin
        if (alloc_fire) tag_q[victim] <= alloc_tag;
    end

    // Callers must never install a tag that is already resident.
    assert property (@(posedge clk) disable iff (!reset) alloc_fire |-> !alloc_dup);

endmodule

// File: tb/tb_lru_fill_ctrl.sv
// Directed bench for lru_fill_ctrl (DEPTH=4, TAGW=8, NUM_REQS=2) with hand-computed expectations.
module tb_lru_fill_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        alloc_valid;
    logic [7:0]  alloc_tag;
    logic        alloc_ready;
    logic [1:0]  alloc_idx;
    logic        alloc_evict;
    logic [7:0]  alloc_evict_tag;
    logic [1:0]  lkp_valid;
    logic [15:0] lkp_tag;
    logic [1:0]  lkp_ready;
    logic        lkp_rsp_valid;
    logic        lkp_rsp_hit;
    logic [1:0]  lkp_rsp_idx;
    logic [0:0]  lkp_rsp_req;
    logic        release_valid;
    logic [1:0]  release_idx;
    logic        flush;
    logic        flush_busy;
    logic [2:0]  size;

    int checks = 0;
    int errors = 0;

    lru_fill_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .alloc_valid     (alloc_valid),
        .alloc_tag       (alloc_tag),
        .alloc_ready     (alloc_ready),
        .alloc_idx       (alloc_idx),
        .alloc_evict     (alloc_evict),
        .alloc_evict_tag (alloc_evict_tag),
        .lkp_valid       (lkp_valid),
        .lkp_tag         (lkp_tag),
        .lkp_ready       (lkp_ready),
        .lkp_rsp_valid   (lkp_rsp_valid),
        .lkp_rsp_hit     (lkp_rsp_hit),
        .lkp_rsp_idx     (lkp_rsp_idx),
        .lkp_rsp_req     (lkp_rsp_req),
        .release_valid   (release_valid),
        .release_idx     (release_idx),
        .flush           (flush),
        .flush_busy      (flush_busy),
        .size            (size)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [1:0] gnt_exp [4];
        gnt_exp[0] = 2'b01;
        gnt_exp[1] = 2'b10;
        gnt_exp[2] = 2'b01;
        gnt_exp[3] = 2'b10;

        reset         = 1'b0;
        alloc_valid   = 1'b0;
        alloc_tag     = '0;
        lkp_valid     = '0;
        lkp_tag       = '0;
        release_valid = 1'b0;
        release_idx   = '0;
        flush         = 1'b0;
        repeat (2) tick();
        chk("rst_size", 32'(size), 0);
        chk("rst_busy", 32'(flush_busy), 0);
        chk("rst_rsp_valid", 32'(lkp_rsp_valid), 0);
        reset = 1'b1;

        // Fill: free slots are taken lowest-first.
        for (int i = 0; i < 4; i++) begin
            alloc_valid = 1'b1;
            alloc_tag   = 8'h10 + 8'(i);
            #1;
            chk("fill_ready", 32'(alloc_ready), 1);
            chk("fill_idx", 32'(alloc_idx), 32'(i));
            chk("fill_evict", 32'(alloc_evict), 0);
            tick();
        end
        alloc_valid = 1'b0;
        #1;
        chk("fill_size", 32'(size), 4);

        // Lookup 0x10 by req0: hit idx0, order becomes [1,2,3,0], rr=1.
        lkp_valid = 2'b01;
        lkp_tag   = {8'h00, 8'h10};
        #1;
        chk("lkp0_ready", 32'(lkp_ready), 32'b01);
        tick();
        lkp_valid = 2'b00;
        #1;
        chk("lkp0_rsp_valid", 32'(lkp_rsp_valid), 1);
        chk("lkp0_rsp_hit", 32'(lkp_rsp_hit), 1);
        chk("lkp0_rsp_idx", 32'(lkp_rsp_idx), 0);
        chk("lkp0_rsp_req", 32'(lkp_rsp_req), 0);
        tick();
        chk("lkp0_rsp_once", 32'(lkp_rsp_valid), 0);

        // Full buffer: victim is LRU entry 1 (tag 0x11).
        alloc_valid = 1'b1;
        alloc_tag   = 8'h20;
        #1;
        chk("evict_idx", 32'(alloc_idx), 1);
        chk("evict_flag", 32'(alloc_evict), 1);
        chk("evict_tag", 32'(alloc_evict_tag), 32'h11);
        tick();
        alloc_valid = 1'b0;

        // Lookup by req1 returns rr to 0 before the arbitration run.
        lkp_valid = 2'b10;
        lkp_tag   = {8'h12, 8'h00};
        #1;
        chk("lkp1_ready", 32'(lkp_ready), 32'b10);
        tick();
        lkp_valid = 2'b00;
        #1;
        chk("lkp1_rsp_hit", 32'(lkp_rsp_hit), 1);
        chk("lkp1_rsp_idx", 32'(lkp_rsp_idx), 2);
        chk("lkp1_rsp_req", 32'(lkp_rsp_req), 1);
        tick();

        // Both requesters held: req0 tag 0x13 hits idx3, req1 tag 0x55 misses.
        lkp_valid = 2'b11;
        lkp_tag   = {8'h55, 8'h13};
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("arb_grant", 32'(lkp_ready), 32'(gnt_exp[k]));
            if (k > 0) begin
                chk("arb_rsp_valid", 32'(lkp_rsp_valid), 1);
                chk("arb_rsp_req", 32'(lkp_rsp_req), 32'((k - 1) % 2));
                chk("arb_rsp_hit", 32'(lkp_rsp_hit), 32'(((k - 1) % 2) == 0));
                chk("arb_rsp_idx", 32'(lkp_rsp_idx), ((k - 1) % 2 == 0) ? 3 : 0);
            end
            tick();
        end
        lkp_valid = 2'b00;
        #1;
        chk("arb_last_req", 32'(lkp_rsp_req), 1);
        chk("arb_last_hit", 32'(lkp_rsp_hit), 0);
        tick();

        // Release wins over alloc and lookup in the same cycle.
        release_valid = 1'b1;
        release_idx   = 2'd2;
        alloc_valid   = 1'b1;
        alloc_tag     = 8'h30;
        lkp_valid     = 2'b01;
        #1;
        chk("prio_alloc_ready", 32'(alloc_ready), 0);
        chk("prio_lkp_ready", 32'(lkp_ready), 0);
        tick();
        release_valid = 1'b0;
        #1;
        chk("rel_size", 32'(size), 3);
        chk("rel_alloc_ready", 32'(alloc_ready), 1);
        chk("rel_alloc_idx", 32'(alloc_idx), 2);
        chk("rel_alloc_evict", 32'(alloc_evict), 0);
        chk("alloc_blocks_lkp", 32'(lkp_ready), 0);
        tick();
        alloc_valid = 1'b0;
        lkp_valid   = 2'b00;
        #1;
        chk("prio_size", 32'(size), 4);
        chk("prio_no_rsp", 32'(lkp_rsp_valid), 0);

        // Flush with four valid entries; a second flush pulse mid-sequence is ignored.
        flush       = 1'b1;
        alloc_valid = 1'b1;
        alloc_tag   = 8'h40;
        #1;
        chk("flush_start_ready", 32'(alloc_ready), 0);
        tick();
        for (int k = 0; k < 4; k++) begin
            flush = (k == 1);
            #1;
            chk("flush_busy", 32'(flush_busy), 1);
            chk("flush_ready", 32'(alloc_ready), 0);
            tick();
        end
        flush = 1'b0;
        #1;
        chk("flush_done_busy", 32'(flush_busy), 0);
        chk("flush_done_size", 32'(size), 0);
        chk("flush_done_ready", 32'(alloc_ready), 1);
        chk("flush_done_idx", 32'(alloc_idx), 0);
        chk("flush_done_evict", 32'(alloc_evict), 0);
        tick();
        alloc_tag = 8'h41;
        #1;
        chk("post_flush_idx", 32'(alloc_idx), 1);
        tick();
        alloc_valid = 1'b0;
        #1;
        chk("post_flush_size", 32'(size), 2);

        // Reset during flush cycle 2.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("rf_busy1", 32'(flush_busy), 1);
        tick();
        chk("rf_size_mid", 32'(size), 1);
        reset = 1'b0;
        #1;
        chk("rf_busy", 32'(flush_busy), 0);
        chk("rf_size", 32'(size), 0);
        chk("rf_rsp_valid", 32'(lkp_rsp_valid), 0);
        tick();
        reset = 1'b1;
        alloc_valid = 1'b1;
        alloc_tag   = 8'h50;
        #1;
        chk("rf_alloc_idx", 32'(alloc_idx), 0);
        tick();
        alloc_valid = 1'b0;

        // Reset while a lookup response is pending.
        lkp_valid = 2'b10;
        lkp_tag   = {8'h50, 8'h00};
        #1;
        chk("rl_grant", 32'(lkp_ready), 32'b10);
        tick();
        lkp_valid = 2'b00;
        #1;
        chk("rl_rsp_valid", 32'(lkp_rsp_valid), 1);
        chk("rl_rsp_hit", 32'(lkp_rsp_hit), 1);
        reset = 1'b0;
        #1;
        chk("rl_rsp_drop", 32'(lkp_rsp_valid), 0);
        chk("rl_size", 32'(size), 0);
        tick();
        reset = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
